// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one fixed-latency main-memory port between the
//             instruction-fetch and data-cache requesters.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_data_in  [4],
  input  logic [7:0]  mem_data_out [4],
  output logic        mem_write_en,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BUSY_I = 3'd1,
    S_BUSY_D = 3'd2,
    S_RESP_I = 3'd3,
    S_RESP_D = 3'd4
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        last_d_q;
  logic        we_q;

  logic        sel_data;
  logic [31:0] rd_word;
  logic        unused_addr_lsbs;

  // Data wins unless it was also the port served last time.
  assign sel_data         = d_req & (~i_req | ~last_d_q);
  assign rd_word          = {mem_data_out[0], mem_data_out[1], mem_data_out[2], mem_data_out[3]};
  assign busy             = (state_q != S_IDLE);
  assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      last_d_q     <= 1'b0;
      we_q         <= 1'b0;
      mem_addr     <= 32'd0;
      for (int k = 0; k < 4; k++) mem_data_in[k] <= 8'd0;
      mem_write_en <= 1'b0;
      i_ready      <= 1'b0;
      d_ready      <= 1'b0;
      i_rdata      <= 32'd0;
      d_rdata      <= 32'd0;
    end else begin
      i_ready      <= 1'b0;
      d_ready      <= 1'b0;
      mem_write_en <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_req || d_req) begin
            cnt_q <= LAT_M1;
            if (sel_data) begin
              state_q        <= S_BUSY_D;
              last_d_q       <= 1'b1;
              mem_addr       <= {d_addr[31:2], 2'b00};
              we_q           <= d_we;
              mem_data_in[0] <= d_wdata[31:24];
              mem_data_in[1] <= d_wdata[23:16];
              mem_data_in[2] <= d_wdata[15:8];
              mem_data_in[3] <= d_wdata[7:0];
              // With a single-cycle memory the strobe cycle is the first BUSY cycle.
              mem_write_en   <= d_we && (MEM_LATENCY == 1);
            end else begin
              state_q  <= S_BUSY_I;
              last_d_q <= 1'b0;
              mem_addr <= {i_addr[31:2], 2'b00};
            end
          end
        end
        S_BUSY_I: begin
          if (cnt_q == 4'd0) begin
            i_rdata <= rd_word;
            i_ready <= 1'b1;
            state_q <= S_RESP_I;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_BUSY_D: begin
          if (cnt_q == 4'd0) begin
            if (!we_q) d_rdata <= rd_word;
            d_ready <= 1'b1;
            state_q <= S_RESP_D;
          end else begin
            cnt_q        <= cnt_q - 4'd1;
            mem_write_en <= we_q && (cnt_q == 4'd1);
          end
        end
        S_RESP_I: state_q <= S_IDLE;
        S_RESP_D: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter at latencies 3 and 1.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk   = 1'b0;
  logic        rst_b = 1'b0;
  logic        ireq3 = 1'b0, dreq3 = 1'b0, ireq1 = 1'b0, dreq1 = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        d_we = 1'b0;

  logic        ir3, dr3, mwe3, bsy3, ir1, dr1, mwe1, bsy1;
  logic [31:0] ird3, drd3, ma3, ird1, drd1, ma1;
  logic [7:0]  mdi3 [4], mdo3 [4], mdi1 [4], mdo1 [4];
  logic [31:0] w3, w1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(3)) u_l3 (
    .clk(clk), .rst_b(rst_b),
    .i_req(ireq3), .i_addr(i_addr), .i_ready(ir3), .i_rdata(ird3),
    .d_req(dreq3), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(dr3), .d_rdata(drd3),
    .mem_addr(ma3), .mem_data_in(mdi3), .mem_data_out(mdo3),
    .mem_write_en(mwe3), .busy(bsy3)
  );

  mem_port_arbiter #(.MEM_LATENCY(1)) u_l1 (
    .clk(clk), .rst_b(rst_b),
    .i_req(ireq1), .i_addr(i_addr), .i_ready(ir1), .i_rdata(ird1),
    .d_req(dreq1), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(dr1), .d_rdata(drd1),
    .mem_addr(ma1), .mem_data_in(mdi1), .mem_data_out(mdo1),
    .mem_write_en(mwe1), .busy(bsy1)
  );

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    if (a == 32'h08) return 32'hCAFEF00D;
    return a * 32'h9E3779B1 + 32'h01234567;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  // Combinational memory image for each instance
  always_comb begin
    w3 = memfn(ma3);
    w1 = memfn(ma1);
    mdo3[0] = w3[31:24]; mdo3[1] = w3[23:16]; mdo3[2] = w3[15:8]; mdo3[3] = w3[7:0];
    mdo1[0] = w1[31:24]; mdo1[1] = w1[23:16]; mdo1[2] = w1[15:8]; mdo1[3] = w1[7:0];
  end

  logic        o_ir [2], o_dr [2], o_mwe [2], o_bsy [2];
  logic [31:0] o_ird [2], o_drd [2], o_ma [2], o_md [2];
  always_comb begin
    o_ir[0] = ir3;   o_dr[0] = dr3;   o_mwe[0] = mwe3; o_bsy[0] = bsy3;
    o_ird[0] = ird3; o_drd[0] = drd3; o_ma[0] = ma3;
    o_md[0] = {mdi3[0], mdi3[1], mdi3[2], mdi3[3]};
    o_ir[1] = ir1;   o_dr[1] = dr1;   o_mwe[1] = mwe1; o_bsy[1] = bsy1;
    o_ird[1] = ird1; o_drd[1] = drd1; o_ma[1] = ma1;
    o_md[1] = {mdi1[0], mdi1[1], mdi1[2], mdi1[3]};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: a grant starts a window of phases 1..L (access),
  // L+1 (response), after which the port is free again.
  bit          m_act [2], m_kd [2], m_we [2], m_last [2];
  int          m_p [2];
  logic [31:0] m_ma [2], m_md [2], m_ird [2], m_drd [2];

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int k = 0; k < 2; k++) begin
        m_act[k] = 0; m_kd[k] = 0; m_we[k] = 0; m_last[k] = 0; m_p[k] = 0;
        m_ma[k] = '0; m_md[k] = '0; m_ird[k] = '0; m_drd[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic ri, rq;
        ri = (k == 0) ? ireq3 : ireq1;
        rq = (k == 0) ? dreq3 : dreq1;
        if (m_act[k]) begin
          m_p[k]++;
          if (m_p[k] == lat(k) + 1) begin
            if (!m_kd[k])     m_ird[k] = memfn(m_ma[k]);
            else if (!m_we[k]) m_drd[k] = memfn(m_ma[k]);
          end
          if (m_p[k] == lat(k) + 2) m_act[k] = 0;
        end else if (ri || rq) begin
          m_kd[k]   = rq && !(ri && m_last[k]);
          m_last[k] = m_kd[k];
          m_act[k]  = 1;
          m_p[k]    = 1;
          if (m_kd[k]) begin
            m_ma[k] = d_addr & 32'hFFFF_FFFC;
            m_we[k] = d_we;
            m_md[k] = d_wdata;
          end else begin
            m_ma[k] = i_addr & 32'hFFFF_FFFC;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int L;
      L = lat(k);
      chk($sformatf("L%0d busy", L),         32'(o_bsy[k]), 32'(m_act[k]));
      chk($sformatf("L%0d mem_write_en", L), 32'(o_mwe[k]), 32'(m_act[k] && m_kd[k] && m_we[k] && m_p[k] == L));
      chk($sformatf("L%0d i_ready", L),      32'(o_ir[k]),  32'(m_act[k] && !m_kd[k] && m_p[k] == L + 1));
      chk($sformatf("L%0d d_ready", L),      32'(o_dr[k]),  32'(m_act[k] && m_kd[k] && m_p[k] == L + 1));
      chk($sformatf("L%0d i_rdata", L),      o_ird[k], m_ird[k]);
      chk($sformatf("L%0d d_rdata", L),      o_drd[k], m_drd[k]);
      chk($sformatf("L%0d mem_addr", L),     o_ma[k],  m_ma[k]);
      chk($sformatf("L%0d mem_data_in", L),  o_md[k],  m_md[k]);
    end
  end

  typedef struct {
    bit          l1;
    bit          d;
    bit          we;
    bit          chg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_maddr;
    logic [31:0] exp_md;
    logic [31:0] exp_rd;
    bit          keep;
  } vec_t;

  vec_t vecs [6];

  task automatic set_req(input bit l1, input bit d, input logic v);
    if (l1) begin if (d) dreq1 = v; else ireq1 = v; end
    else    begin if (d) dreq3 = v; else ireq3 = v; end
  endtask

  task automatic run_vec(input vec_t v);
    int          k, L;
    logic [31:0] prev;
    k = v.l1 ? 1 : 0;
    L = lat(k);
    @(negedge clk);
    i_addr = v.addr; d_addr = v.addr; d_we = v.we; d_wdata = v.wdata;
    prev = v.d ? o_drd[k] : o_ird[k];
    set_req(v.l1, v.d, 1'b1);
    for (int c = 1; c <= L + 1; c++) begin
      @(negedge clk);
      if (v.chg && c == 1) begin d_addr = ~v.addr; d_wdata = ~v.wdata; end
      chk("vec busy",         32'(o_bsy[k]), 32'd1);
      chk("vec mem_addr",     o_ma[k], v.exp_maddr);
      if (v.d) chk("vec mem_data_in", o_md[k], v.exp_md);
      chk("vec mem_write_en", 32'(o_mwe[k]), 32'(v.d && v.we && c == L));
      chk("vec i_ready",      32'(o_ir[k]),  32'(!v.d && c == L + 1));
      chk("vec d_ready",      32'(o_dr[k]),  32'(v.d && c == L + 1));
      if (c == L + 1) begin
        chk("vec rdata", v.d ? o_drd[k] : o_ird[k], v.keep ? prev : v.exp_rd);
        set_req(v.l1, v.d, 1'b0);
      end
    end
    @(negedge clk);
    chk("vec idle", 32'(o_bsy[k]), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 0, 0, 0, 32'h13, 32'h0,        32'h10, 32'h0,        32'hDEADBEEF,  0};
    vecs[1] = '{0, 1, 1, 0, 32'h40, 32'h11223344, 32'h40, 32'h11223344, 32'h0,         1};
    vecs[2] = '{0, 1, 0, 0, 32'h22, 32'hFFFF0000, 32'h20, 32'hFFFF0000, memfn(32'h20), 0};
    vecs[3] = '{0, 1, 1, 1, 32'h7F, 32'hA1B2C3D4, 32'h7C, 32'hA1B2C3D4, 32'h0,         1};
    vecs[4] = '{1, 1, 0, 0, 32'h08, 32'h0,        32'h08, 32'h0,        32'hCAFEF00D,  0};
    vecs[5] = '{1, 0, 0, 0, 32'h03, 32'h0,        32'h00, 32'h0,        32'h01234567,  0};

    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Asynchronous reset landing one cycle before the write strobe
    @(negedge clk);
    d_addr = 32'h40; d_we = 1'b1; d_wdata = 32'h55667788; dreq3 = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_b = 1'b0; dreq3 = 1'b0;
    #1;
    chk("rst busy",         32'(bsy3), 32'd0);
    chk("rst mem_write_en", 32'(mwe3), 32'd0);
    chk("rst i_ready",      32'(ir3),  32'd0);
    chk("rst d_ready",      32'(dr3),  32'd0);
    chk("rst i_rdata",      ird3, 32'd0);
    chk("rst d_rdata",      drd3, 32'd0);
    chk("rst mem_addr",     ma3,  32'd0);
    chk("rst mem_data_in",  o_md[0], 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst no write", 32'(mwe3), 32'd0);
    end
    rst_b = 1'b1;

    // Both requesters held: data wins first, then strict alternation
    @(negedge clk);
    i_addr = 32'h100; d_addr = 32'h200; d_we = 1'b0;
    ireq3 = 1'b1; dreq3 = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      chk($sformatf("alt d_ready c%0d", c), 32'(dr3), 32'(c == 4 || c == 14));
      chk($sformatf("alt i_ready c%0d", c), 32'(ir3), 32'(c == 9 || c == 19));
    end
    ireq3 = 1'b0; dreq3 = 1'b0;
    repeat (3) @(negedge clk);

    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) ireq3 = ~ireq3;
      if ($urandom_range(0, 3) == 0) dreq3 = ~dreq3;
      if ($urandom_range(0, 3) == 0) ireq1 = ~ireq1;
      if ($urandom_range(0, 3) == 0) dreq1 = ~dreq1;
      i_addr  = $urandom;
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_we    = 1'($urandom_range(0, 1));
    end
    ireq3 = 1'b0; dreq3 = 1'b0; ireq1 = 1'b0; dreq1 = 1'b0;
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the core's single main-memory port between the instruction-fetch requester and the data-cache requester. Each requester presents a level request; the arbiter grants one at a time, drives the memory address, data and write enable for a fixed latency window, then returns read data with a one-cycle ready pulse. It sits between the PC/fetch logic and the cache on one side and main memory on the other.

## Interface
- MEM_LATENCY, 4: cycles the memory needs per access; legal range 1..15.
- clk  in  1  clock; all state changes on the rising edge.
- rst_b  in  1  reset; asynchronous assertion, active low.
- i_req  in  1  instruction-fetch request, level, held until i_ready.
- i_addr  in  32  fetch byte address.
- i_ready  out  1  one-cycle pulse: fetch complete, i_rdata valid.
- i_rdata  out  32  fetched word, held until the next fetch completes.
- d_req  in  1  data request, level, held until d_ready.
- d_we  in  1  data write (1) / read (0), sampled at grant.
- d_addr  in  32  data byte address, sampled at grant.
- d_wdata  in  32  write data, sampled at grant.
- d_ready  out  1  one-cycle pulse: data access complete, d_rdata valid on reads.
- d_rdata  out  32  read word, held until the next data read completes.
- mem_addr  out  32  word-aligned address to memory.
- mem_data_in  out  4x8  write data to memory; [0] = bits 31:24 ... [3] = bits 7:0.
- mem_data_out  in  4x8  read data from memory, same byte order.
- mem_write_en  out  1  memory write strobe.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE: only i_req -> BUSY_I; only d_req -> BUSY_D; both -> port not granted last (last_grant), then last_grant updated; neither -> stay.
- On grant: mem_addr <= {addr[31:2], 2'b00} (low two bits dropped, no alignment fault); for data, d_we/d_wdata latched internally and d_wdata driven on mem_data_in; counter <= MEM_LATENCY-1.
- BUSY_x: counter decrements each cycle; mem_addr, mem_data_in held stable. When counter == 0: read data captured from mem_data_out into i_rdata/d_rdata (data writes leave d_rdata unchanged), go to RESP_x.
- mem_write_en high only in the BUSY_D cycle where counter == 0 and latched we = 1; exactly one write edge per write transaction.
- RESP_x: x_ready = 1 for exactly this cycle, no new grant, -> IDLE. A requester still asserting req in the following IDLE cycle is a new request.
- Request inputs changing while not in IDLE are ignored; latched values govern the in-flight access.
- Reset value of last_grant = instruction, so the first conflict is won by data.

## Timing
- Reset (async, any state, including mid-write): state IDLE, counter 0, last_grant = I; mem_addr 0, mem_data_in all 0, mem_write_en 0, i_ready/d_ready 0, i_rdata/d_rdata 0, busy 0. An aborted write never asserts mem_write_en.
- Request high in IDLE cycle 0 -> BUSY cycles 1..MEM_LATENCY -> ready in cycle MEM_LATENCY+1 -> IDLE in MEM_LATENCY+2.
- Back-to-back throughput: one access per MEM_LATENCY+2 cycles; with both requests held continuously, grants alternate D, I, D, I.
- MEM_LATENCY = 1: single BUSY cycle; capture and write strobe in that cycle.
- busy follows state combinationally from registered state; all other outputs registered.

## Test plan
- Reset: drive rst_b low mid-BUSY_D write, L=3 -> all outputs 0 immediately, no mem_write_en pulse, next i_req served normally.
- Single fetch, L=3, i_addr=0x0000_0013, memory returns 0xDEADBEEF -> mem_addr=0x0000_0010 cycles 1-3, i_ready pulse cycle 4, i_rdata=0xDEADBEEF.
- Data write, L=3, d_addr=0x40, d_wdata=0x11223344 -> mem_data_in = {0x11,0x22,0x33,0x44}, mem_write_en high in cycle 3 only, d_ready cycle 4, d_rdata unchanged.
- Simultaneous i_req and d_req held after reset -> grant order D, I, D, I; ready pulses in cycles 4, 9, 14, 19 (L=3).
- d_addr/d_wdata changed during BUSY_D -> memory sees only values latched at grant.
- L=1 read at 0x8 returning 0xCAFEF00D -> BUSY cycle 1, d_ready cycle 2, d_rdata=0xCAFEF00D.
